// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one barrel stage per clock, MSB stage first.
// Logical or arithmetic fill, valid/ready handshake on both sides.
module shift_right_seq #(
    parameter int Nbits = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [Nbits-1:0] A,
    input  logic [Nbits-1:0] B,
    input  logic             ARITH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [Nbits-1:0] OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int CW = (Nbits > 1) ? $clog2(Nbits) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t             state;
    logic [Nbits-1:0]   dreg;
    logic [Nbits-1:0]   breg;
    logic               fill;
    logic [CW-1:0]      cnt;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [2*Nbits-1:0] ext;
    logic [2*Nbits-1:0] tmp;
    logic [Nbits-1:0]   shifted;

    // Stage cnt shifts by 2**cnt; strides at or beyond the width saturate to fill.
    always_comb begin
        ext     = {{Nbits{fill}}, dreg};
        tmp     = ext;
        shifted = dreg;
        for (int s = 0; s < Nbits; s++) begin
            if (cnt == CW'(s) && breg[s]) begin
                if (s >= 31 || (1 << s) >= Nbits) begin
                    shifted = {Nbits{fill}};
                end else begin
                    tmp     = ext >> (1 << s);
                    shifted = tmp[Nbits-1:0];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            dreg        <= '0;
            breg        <= '0;
            fill        <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        dreg       <= A;
                        breg       <= B;
                        fill       <= ARITH & A[Nbits-1];
                        cnt        <= CW'(Nbits - 1);
                        in_ready_q <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    dreg <= shifted;
                    if (cnt == '0) begin
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign OUT       = dreg;
    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: vector table, exhaustive model sweep,
// backpressure and mid-operation reset sequences.
module tb_shift_right_seq;

    logic       CLK;
    logic       RST;
    logic [3:0] A;
    logic [3:0] B;
    logic       ARITH;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] OUT;
    logic       OUT_VALID;
    logic       OUT_READY;

    int n_cmp;
    int n_err;
    logic [3:0] sb[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       arith;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[12];

    shift_right_seq #(.Nbits(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .A(A),
        .B(B),
        .ARITH(ARITH),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .OUT(OUT),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic ar);
        logic signed [3:0] sa;
        sa = a;
        if (ar) return sa >>> b;
        return a >> b;
    endfunction

    // Issue at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b,
                            input logic ar, input logic [3:0] exp);
        chk("in_ready_idle", IN_READY, 1);
        A = a;
        B = b;
        ARITH = ar;
        IN_VALID = 1'b1;
        sb.push_back(exp);
        @(negedge CLK);
        IN_VALID = 1'b0;
        A = ~a;
        B = ~b;
        ARITH = ~ar;
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            chk("in_ready_busy", IN_READY, 0);
            @(negedge CLK);
            lat++;
        end
        chk("latency", lat, 4);
    endtask

    task automatic collect(input int stall);
        logic [3:0] held;
        logic [3:0] exp;
        held = OUT;
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            chk("stall_valid", OUT_VALID, 1);
            chk("stall_out", OUT, held);
            chk("stall_in_ready", IN_READY, 0);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            exp = 'x;
        end else begin
            exp = sb.pop_front();
        end
        chk("out", OUT, exp);
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("valid_drop", OUT_VALID, 0);
        chk("in_ready_back", IN_READY, 1);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic ar, input logic [3:0] exp,
                          input int stall);
        start_op(a, b, ar, exp);
        wait_done();
        collect(stall);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST = 1'b1;
        A = '0;
        B = '0;
        ARITH = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;

        vecs[0]  = '{4'b1011, 4'b0001, 1'b0, 4'b0101};
        vecs[1]  = '{4'b1011, 4'b0010, 1'b1, 4'b1110};
        vecs[2]  = '{4'b1011, 4'b0010, 1'b0, 4'b0010};
        vecs[3]  = '{4'b1000, 4'b0100, 1'b0, 4'b0000};
        vecs[4]  = '{4'b1000, 4'b0100, 1'b1, 4'b1111};
        vecs[5]  = '{4'b1000, 4'b1111, 1'b0, 4'b0000};
        vecs[6]  = '{4'b1000, 4'b1111, 1'b1, 4'b1111};
        vecs[7]  = '{4'b0111, 4'b1111, 1'b1, 4'b0000};
        vecs[8]  = '{4'b1001, 4'b0000, 1'b0, 4'b1001};
        vecs[9]  = '{4'b1001, 4'b0000, 1'b1, 4'b1001};
        vecs[10] = '{4'b0110, 4'b0011, 1'b1, 4'b0000};
        vecs[11] = '{4'b1110, 4'b0011, 1'b1, 4'b1111};

        #12;
        chk("rst_out", OUT, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].arith, vecs[i].exp, 0);

        for (int i = 0; i < 512; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       ar;
            a = 4'(i);
            b = 4'(i >> 4);
            ar = i[8];
            run_op(a, b, ar, model(a, b, ar), 0);
        end

        // Backpressure with a competing request held by the source.
        start_op(4'b1101, 4'b0001, 1'b1, 4'b1110);
        wait_done();
        A = 4'b1111;
        B = 4'b0000;
        ARITH = 1'b0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("bp_valid", OUT_VALID, 1);
            chk("bp_out", OUT, 4'b1110);
            chk("bp_in_ready", IN_READY, 0);
        end
        chk("bp_result", OUT, sb.pop_front());
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("bp_valid_drop", OUT_VALID, 0);
        chk("bp_in_ready_back", IN_READY, 1);
        sb.push_back(4'b1111);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("bp_accepted", IN_READY, 0);
        wait_done();
        collect(0);

        // Reset during the second SHIFT cycle.
        start_op(4'b0110, 4'b0001, 1'b0, 4'b0011);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("midrst_valid", OUT_VALID, 0);
        chk("midrst_in_ready", IN_READY, 1);
        chk("midrst_out", OUT, 0);
        void'(sb.pop_front());
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("midrst_no_pulse", OUT_VALID, 0);
        end
        run_op(4'b1100, 4'b0001, 1'b1, 4'b1110, 2);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
